uart_ctrl: RTL

Byte-level controller sitting directly upstream of `uart_unit`, between it and the core's I/O port. It buffers outgoing bytes in a TX FIFO and received bytes in an RX FIFO. It issues one `uart_unit` operation at a time: a `uart_go` pulse with `rors` selecting send or receive, completed by `uart_done`. The core only sees two ready/valid byte streams and never drives the UART handshake directly.

---
 rtl/uart_ctrl_if.sv | 29 ++
 rtl/uart_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/uart_ctrl_if.sv
// Core-side byte streams and uart_unit handshake for uart_ctrl.
// master: the core plus uart_unit (the environment); slave: the controller.
interface uart_ctrl_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  tx_valid;
  logic [7:0]            tx_data;
  logic                  tx_ready;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  rx_en;
  logic [DEPTH_LOG2:0]   rx_count;
  logic                  uart_go;
  logic                  rors;
  logic [7:0]            txdata;
  logic                  uart_done;
  logic [7:0]            rxdata;

  modport master (
    output tx_valid, tx_data, rx_ready, rx_en, uart_done, rxdata,
    input  tx_ready, rx_valid, rx_data, rx_count, uart_go, rors, txdata
  );

  modport slave (
    input  tx_valid, tx_data, rx_ready, rx_en, uart_done, rxdata,
    output tx_ready, rx_valid, rx_data, rx_count, uart_go, rors, txdata
  );
endinterface

// File: rtl/uart_ctrl.sv
// Byte-level controller in front of uart_unit: TX and RX FIFOs plus a
// three-state sequencer that keeps at most one uart_unit operation in flight.
// TX always wins over RX; RX space is reserved when a receive is started.
module uart_ctrl #(
  parameter int DEPTH_LOG2 = 4
) (
  input logic        clk,
  input logic        rst,
  uart_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL    = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] RECV = 2'd2;

  logic [1:0]            state;
  logic                  go_q;
  logic                  rors_q;
  logic [7:0]            txdata_q;

  logic [7:0]            tx_mem [DEPTH];
  logic [7:0]            rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_rd, tx_wr, rx_rd, rx_wr;
  logic [DEPTH_LOG2:0]   tx_count, rx_count;

  logic tx_push, tx_pop, rx_push, rx_pop, start_recv, op_done;

  // done is only honoured while an operation is outstanding and past its go cycle
  assign op_done    = (state != IDLE) && !go_q && bus.uart_done;
  assign tx_push    = bus.tx_valid && (tx_count != FULL);
  assign tx_pop     = (state == IDLE) && (tx_count != '0);
  assign start_recv = (state == IDLE) && (tx_count == '0) && bus.rx_en && (rx_count != FULL);
  assign rx_push    = op_done && (state == RECV);
  assign rx_pop     = (rx_count != '0) && bus.rx_ready;

  assign bus.tx_ready = (tx_count != FULL);
  assign bus.rx_valid = (rx_count != '0);
  assign bus.rx_data  = rx_mem[rx_rd];
  assign bus.rx_count = rx_count;
  assign bus.uart_go  = go_q && !rst;
  assign bus.rors     = rors_q;
  assign bus.txdata   = txdata_q;

  // Sequencer: pick the next operation in IDLE and wait for its completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      go_q     <= 1'b0;
      rors_q   <= 1'b0;
      txdata_q <= 8'h00;
    end else begin
      go_q <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_pop) begin
            txdata_q <= tx_mem[tx_rd];
            rors_q   <= 1'b1;
            go_q     <= 1'b1;
            state    <= SEND;
          end else if (start_recv) begin
            rors_q <= 1'b0;
            go_q   <= 1'b1;
            state  <= RECV;
          end
        end
        SEND, RECV: begin
          if (op_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage; contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= bus.tx_data;
    if (rx_push) rx_mem[rx_wr] <= bus.rxdata;
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_rd    <= '0;
      tx_wr    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PTR_ONE;
      if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CNT_ONE;
        2'b01:   tx_count <= tx_count - CNT_ONE;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_rd    <= '0;
      rx_wr    <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + PTR_ONE;
      if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CNT_ONE;
        2'b01:   rx_count <= rx_count - CNT_ONE;
        default: rx_count <= rx_count;
      endcase
    end
  end
endmodule
